// File: rtl/vnlp_list_engine.sv
// rtl/vnlp_list_engine.sv - walks two linked lists in a dual-read-port memory
// and accumulates a saturating sum of products or absolute differences.
module vnlp_list_engine #(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 9,
  parameter int ACC_W   = 28,
  parameter int LEN_W   = 8,
  parameter int MAX_LEN = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] Head1,
  input  logic [ADDR_W-1:0] Head2,
  output logic [ADDR_W-1:0] MemAdd1,
  output logic [ADDR_W-1:0] MemAdd2,
  input  logic [DATA_W-1:0] MemData1,
  input  logic [DATA_W-1:0] MemData2,
  output logic              Busy,
  output logic              Done,
  output logic [LEN_W-1:0]  Len,
  output logic [ACC_W-1:0]  Result,
  output logic              Overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_D, S_FETCH_N, S_UPDATE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   ptr1_q, ptr1_d, ptr2_q, ptr2_d;
  logic [DATA_W-1:0]   d1_q, d1_d, d2_q, d2_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic                ovf_q, ovf_d;

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   diff;
  logic [ACC_W-1:0]    term;
  logic [ACC_W:0]      sum;
  logic [LEN_W-1:0]    len_inc;
  logic [ADDR_W-1:0]   n1, n2;

  assign prod    = {{DATA_W{1'b0}}, d1_q} * {{DATA_W{1'b0}}, d2_q};
  assign diff    = (d1_q >= d2_q) ? (d1_q - d2_q) : (d2_q - d1_q);
  assign term    = mode_q ? ACC_W'(diff) : ACC_W'(prod);
  assign sum     = {1'b0, result_q} + {1'b0, term};
  assign len_inc = len_q + LEN_W'(1);
  assign n1      = ADDR_W'(MemData1);
  assign n2      = ADDR_W'(MemData2);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      ptr1_q   <= '0;
      ptr2_q   <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      len_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ptr1_q   <= ptr1_d;
      ptr2_q   <= ptr2_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      len_q    <= len_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ptr1_d   = ptr1_q;
    ptr2_d   = ptr2_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    len_d    = len_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d   = Mode;
          ptr1_d   = Head1;
          ptr2_d   = Head2;
          len_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = (Head1 == '0 || Head2 == '0) ? S_DONE : S_FETCH_D;
        end
      end
      S_FETCH_D: state_d = S_FETCH_N;
      S_FETCH_N: begin
        d1_d    = MemData1;
        d2_d    = MemData2;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // Saturation is sticky: once pinned at all ones, further terms are ignored.
        if (ovf_q || sum[ACC_W]) begin
          result_d = '1;
          ovf_d    = 1'b1;
        end else begin
          result_d = sum[ACC_W-1:0];
        end
        len_d   = len_inc;
        ptr1_d  = n1;
        ptr2_d  = n2;
        state_d = (n1 == '0 || n2 == '0 || len_inc == LEN_W'(MAX_LEN)) ? S_DONE : S_FETCH_D;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MemAdd1 = '0;
    MemAdd2 = '0;
    case (state_q)
      S_FETCH_D: begin
        MemAdd1 = ptr1_q;
        MemAdd2 = ptr2_q;
      end
      S_FETCH_N: begin
        MemAdd1 = ptr1_q + ADDR_W'(1);
        MemAdd2 = ptr2_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);
  assign Len      = len_q;
  assign Result   = result_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_vnlp_list_engine.sv
// tb/tb_vnlp_list_engine.sv - directed scoreboard bench for vnlp_list_engine
// (ACC_W=20, MAX_LEN=5 so overflow and loop limits are reachable).
module tb_vnlp_list_engine;
  localparam int DATA_W = 10, ADDR_W = 9, ACC_W = 20, LEN_W = 8, MAX_LEN = 5;

  logic              clk = 1'b0;
  logic              rst, start, mode;
  logic [ADDR_W-1:0] head1, head2, mem_add1, mem_add2;
  logic [DATA_W-1:0] mem_data1, mem_data2;
  logic              busy, done, overflow;
  logic [LEN_W-1:0]  len;
  logic [ACC_W-1:0]  result;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  typedef struct {
    int len;
    int res;
    int ovf;
    int cyc;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  vnlp_list_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)
  ) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Mode(mode),
    .Head1(head1), .Head2(head2),
    .MemAdd1(mem_add1), .MemAdd2(mem_add2),
    .MemData1(mem_data1), .MemData2(mem_data2),
    .Busy(busy), .Done(done), .Len(len), .Result(result), .Overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_data1 <= mem[mem_add1];
    mem_data2 <= mem[mem_add2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic node(input int a, input int val, input int nxt);
    mem[a]   = DATA_W'(val);
    mem[a+1] = DATA_W'(nxt);
  endtask

  // Launch a run, push its expectation, then pop and compare when Done rises.
  // With noisy=1, Start stays high (and Mode/heads change) for the whole run.
  task automatic run(input string tag, input logic m, input int h1, input int h2,
                     input int elen, input int eres, input int eovf, input int ecyc,
                     input bit noisy);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    mode = m; head1 = ADDR_W'(h1); head2 = ADDR_W'(h2); start = 1'b1;
    sb.push_back('{elen, eres, eovf, ecyc});
    @(posedge clk);
    #1;
    start = noisy;
    if (noisy) begin
      mode = ~m; head1 = 9'h050; head2 = 9'h060;
    end
    seen = 1'b0;
    cyc  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        cyc  = k;
        break;
      end
    end
    e = sb.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
    check({tag, "_len"}, 32'(len), 32'(e.len));
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(e.res));
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    node(9'h010, 3, 9'h020); node(9'h020, 4, 9'h030); node(9'h030, 5, 0);
    node(9'h100, 2, 9'h110); node(9'h110, 6, 9'h120); node(9'h120, 7, 0);
    node(9'h080, 9, 0);
    node(9'h180, 1023, 9'h190); node(9'h190, 1023, 0);
    node(9'h1A0, 1023, 9'h1B0); node(9'h1B0, 1023, 0);
    node(9'h050, 2, 9'h050);
    node(9'h060, 3, 9'h060);

    rst = 1'b1; start = 1'b0; mode = 1'b0; head1 = '0; head2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_len", 32'(len), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_memadd1", 32'(mem_add1), 32'd0);
    check("rst_memadd2", 32'(mem_add2), 32'd0);
    rst = 1'b0;

    run("dot",      1'b0, 'h010, 'h100, 3, 65, 0, 10, 1'b0);
    run("absdiff",  1'b1, 'h010, 'h100, 3, 5, 0, 10, 1'b0);
    run("unequal",  1'b0, 'h010, 'h080, 1, 27, 0, 4, 1'b0);
    run("empty",    1'b0, 'h010, 'h000, 0, 0, 0, 1, 1'b0);
    run("overflow", 1'b0, 'h180, 'h1A0, 2, 'hFFFFF, 1, 7, 1'b0);
    run("ovf_clear", 1'b0, 'h010, 'h100, 3, 65, 0, 10, 1'b0);
    run("selfloop", 1'b0, 'h050, 'h060, 5, 30, 0, 16, 1'b0);
    run("noisy",    1'b0, 'h010, 'h100, 3, 65, 0, 10, 1'b1);

    // Reset during cycle 4 of a run discards everything.
    @(negedge clk);
    mode = 1'b0; head1 = 9'h010; head2 = 9'h100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_len_before_reset", 32'(len), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_len", 32'(len), 32'd0);
    check("midrun_rst_result", 32'(result), 32'd0);
    check("midrun_rst_overflow", 32'(overflow), 32'd0);
    check("midrun_rst_memadd1", 32'(mem_add1), 32'd0);
    check("midrun_rst_memadd2", 32'(mem_add2), 32'd0);
    rst = 1'b0;

    run("after_reset", 1'b1, 'h010, 'h100, 3, 5, 0, 10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
